// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and status-flag bit positions shared by the ALU files.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'b0000,
      OP_SUB   = 4'b0001,
      OP_AND   = 4'b0010,
      OP_OR    = 4'b0011,
      OP_XOR   = 4'b0100,
      OP_SLL   = 4'b0101,
      OP_SRL   = 4'b0110,
      OP_SRA   = 4'b0111,
      OP_SLT   = 4'b1000,
      OP_SLTU  = 4'b1001,
      OP_PASSB = 4'b1010
   } alu_op_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: log2(WIDTH)-stage barrel shifter; left shifts reuse the right-shift stages on a bit-reversed operand.
module alu_shifter #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   shamt,
   input  logic             left,
   input  logic             arith,
   output logic [WIDTH-1:0] y
);

   logic             fill;
   logic [WIDTH-1:0] rev_in, rev_out, s;

   assign fill = arith & a[WIDTH-1];

   always_comb begin
      for (int i = 0; i < WIDTH; i++) rev_in[i] = a[WIDTH-1-i];
      s = left ? rev_in : a;
      for (int k = 0; k < SHW; k++)
         s = shamt[k] ? ((s >> (2**k)) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> (2**k)))) : s;
      for (int i = 0; i < WIDTH; i++) rev_out[i] = s[WIDTH-1-i];
      y = left ? rev_out : s;
   end

endmodule

// File: rtl/alu.sv
// alu: combinational ALU with one shared add/subtract path and a registered {N,Z,C,V} flag word.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [3:0]       ALUControl,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic [3:0]       FlagsQ
);

   localparam int SHW = $clog2(WIDTH);

   alu_op_t          op;
   logic             sub, arith_op, carry, ovf, lt_s, lt_u;
   logic [WIDTH-1:0] b_eff, shift_res;
   logic [WIDTH:0]   sum;
   logic [3:0]       flags_d, flags_q;

   assign op       = alu_op_t'(ALUControl);
   assign sub      = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
   assign arith_op = (op == OP_ADD) || (op == OP_SUB);
   assign b_eff    = sub ? ~SrcB : SrcB;
   assign sum      = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
   assign carry    = sum[WIDTH];
   assign ovf      = (SrcA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
   // Signed less-than is the difference's sign corrected by overflow; unsigned is a borrow.
   assign lt_s     = sum[WIDTH-1] ^ ovf;
   assign lt_u     = ~carry;

   alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .a     (SrcA),
      .shamt (SrcB[SHW-1:0]),
      .left  (op == OP_SLL),
      .arith (op == OP_SRA),
      .y     (shift_res)
   );

   always_comb begin
      case (op)
         OP_ADD, OP_SUB:          ALUResult = sum[WIDTH-1:0];
         OP_AND:                  ALUResult = SrcA & SrcB;
         OP_OR:                   ALUResult = SrcA | SrcB;
         OP_XOR:                  ALUResult = SrcA ^ SrcB;
         OP_SLL, OP_SRL, OP_SRA:  ALUResult = shift_res;
         OP_SLT:                  ALUResult = {{(WIDTH-1){1'b0}}, lt_s};
         OP_SLTU:                 ALUResult = {{(WIDTH-1){1'b0}}, lt_u};
         OP_PASSB:                ALUResult = SrcB;
         default:                 ALUResult = '0;
      endcase
   end

   assign Zero = (ALUResult == '0);

   always_comb begin
      flags_d         = '0;
      flags_d[FLAG_N] = ALUResult[WIDTH-1];
      flags_d[FLAG_Z] = Zero;
      flags_d[FLAG_C] = arith_op & carry;
      flags_d[FLAG_V] = arith_op & ovf;
   end

   always_ff @(posedge clk) flags_q <= reset ? 4'b0000 : flags_d;

   assign FlagsQ = flags_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench comparing the ALU against a reference model of results and registered flags.
module tb_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] SrcA, SrcB, ALUResult;
   logic [3:0]  ALUControl, FlagsQ;
   logic        Zero;

   int n_cmp = 0;
   int n_err = 0;

   logic [32:0] res_q[$];
   logic [3:0]  flg_q[$];

   alu #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .ALUControl (ALUControl),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .FlagsQ     (FlagsQ)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [3:0] f);
      logic [32:0] s;
      logic        c, v;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
         4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = a << b[4:0];
         4'd6: r = a >> b[4:0];
         4'd7: r = $signed(a) >>> b[4:0];
         4'd8: r = {31'd0, $signed(a) < $signed(b)};
         4'd9: r = {31'd0, a < b};
         4'd10: r = b;
         default: r = 32'd0;
      endcase
      f = {r[31], r == 32'd0, c, v};
   endfunction

   task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rst);
      logic [31:0] r;
      logic [3:0]  f;
      logic [32:0] er;
      logic [3:0]  ef;
      @(negedge clk);
      SrcA = a;
      SrcB = b;
      ALUControl = op;
      reset = rst;
      model(op, a, b, r, f);
      res_q.push_back({r == 32'd0, r});
      flg_q.push_back(rst ? 4'b0000 : f);
      #1;
      er = res_q.pop_front();
      check($sformatf("result op%0h", op), ALUResult, er[31:0]);
      check($sformatf("zero op%0h", op), Zero, er[32]);
      @(posedge clk);
      #1;
      ef = flg_q.pop_front();
      check($sformatf("flags op%0h rst%0b", op, rst), FlagsQ, ef);
   endtask

   initial begin
      reset = 1'b1;
      SrcA = 32'd0;
      SrcB = 32'd0;
      ALUControl = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset flags", FlagsQ, 4'b0000);
      apply(4'h0, 32'd10, 32'd20, 1'b0);
      check("add flags 0000", FlagsQ, 4'b0000);
      apply(4'h1, 32'd100, 32'd40, 1'b0);
      apply(4'h1, 32'd5, 32'd5, 1'b0);
      check("sub equal flags 0110", FlagsQ, 4'b0110);
      apply(4'h4, 32'hF0F0F0F0, 32'hFFFF0000, 1'b0);
      apply(4'h5, 32'd1, 32'd4, 1'b0);
      apply(4'h6, 32'd32, 32'd2, 1'b0);
      apply(4'h7, 32'h80000000, 32'hFFFFFFE4, 1'b0);
      check("sra result", ALUResult, 32'hF8000000);
      apply(4'h0, 32'h7FFFFFFF, 32'd1, 1'b0);
      check("add ovf flags 1001", FlagsQ, 4'b1001);
      apply(4'h8, 32'hFFFFFFFF, 32'd1, 1'b0);
      apply(4'h9, 32'hFFFFFFFF, 32'd1, 1'b0);
      apply(4'hF, 32'hFFFFFFFF, 32'd1, 1'b0);
      apply(4'h2, 32'hDEADBEEF, 32'h0F0F0F0F, 1'b0);
      apply(4'h3, 32'h12340000, 32'h00005678, 1'b0);
      apply(4'hA, 32'd0, 32'h80000001, 1'b0);
      apply(4'h1, 32'd0, 32'd1, 1'b0);
      apply(4'h1, 32'h80000000, 32'd1, 1'b0);
      apply(4'h0, 32'hFFFFFFFF, 32'd1, 1'b0);
      apply(4'h5, 32'h00000001, 32'hFFFFFFFF, 1'b0);
      apply(4'h6, 32'h80000000, 32'd31, 1'b0);
      apply(4'h8, 32'h80000000, 32'h7FFFFFFF, 1'b0);
      apply(4'h9, 32'h7FFFFFFF, 32'h80000000, 1'b0);
      apply(4'hB, 32'd7, 32'd9, 1'b0);
      apply(4'h0, 32'h7FFFFFFF, 32'd1, 1'b0);
      apply(4'h0, 32'h7FFFFFFF, 32'd1, 1'b1);
      check("reset clears flags", FlagsQ, 4'b0000);
      check("result during reset", ALUResult, 32'h80000000);
      apply(4'h0, 32'h7FFFFFFF, 32'd1, 1'b0);
      for (int i = 0; i < 60; i++)
         apply(4'($urandom_range(0, 15)), $urandom, (i % 3 == 0) ? $urandom_range(0, 63) : $urandom, 1'b0);
      check("queues drained", {res_q.size(), flg_q.size()}, 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The module SHALL have port clk  input  1  rising-edge clock for the status-flag register.
REQ-003 The module SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 The module SHALL have port SrcA  input  WIDTH  first operand.
REQ-005 The module SHALL have port SrcB  input  WIDTH  second operand; also the shift-amount source.
REQ-006 The module SHALL have port ALUControl  input  4  operation select.
REQ-007 The module SHALL have port ALUResult  output  WIDTH  combinational result.
REQ-008 The module SHALL have port Zero  output  1  combinational, high when ALUResult == 0.
REQ-009 The module SHALL have port FlagsQ  output  4  registered {N,Z,C,V} of the previous cycle's operation.

Function
REQ-010 ALUResult and Zero SHALL be purely combinational with zero-cycle latency and no dependence on clk or reset.
REQ-011 ALUControl decode SHALL be: 0000 ADD A+B; 0001 SUB A-B; 0010 AND; 0011 OR; 0100 XOR; 0101 SLL A<<B[4:0]; 0110 SRL logical A>>B[4:0]; 0111 SRA arithmetic A>>>B[4:0]; 1000 SLT signed A<B ? 1 : 0; 1001 SLTU unsigned A<B ? 1 : 0; 1010 PASSB result = B.
REQ-012 Codes 1011-1111 SHALL produce ALUResult = 0 (Zero = 1) and SHALL update FlagsQ with C = V = 0.
REQ-013 ADD/SUB SHALL wrap modulo 2^WIDTH; SUB SHALL be computed as A + ~B + 1.
REQ-014 Shift amount SHALL use only SrcB[log2(WIDTH)-1:0] (bits [4:0] for WIDTH=32); upper SrcB bits are ignored.
REQ-015 SLT/SLTU SHALL zero-extend the 1-bit comparison result to WIDTH.
REQ-016 Flag N SHALL equal ALUResult[WIDTH-1] and flag Z SHALL equal Zero.
REQ-017 Flag C SHALL be the adder carry-out for ADD and SUB, where SUB carry = 1 means no borrow; C SHALL be 0 for all other operations.
REQ-018 Flag V SHALL be signed overflow for ADD and SUB and 0 for all other operations.
REQ-019 FlagsQ SHALL load {N,Z,C,V} on every rising clk edge when reset is low, giving one-cycle latency with no enable.
REQ-020 Outputs SHALL NOT contain X for any known inputs; there is no handshake.

Reset
REQ-021 When reset is high at a rising clk edge, FlagsQ SHALL become 4'b0000.
REQ-022 Reset SHALL NOT affect ALUResult or Zero; when reset deasserts, the next edge SHALL capture the current flags.

Structure
REQ-023 Package alu_pkg SHALL define the enum alu_op_t, 4 bits wide, with the REQ-011 encodings, and the flag-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
REQ-024 A single sub-module alu_shifter SHALL implement SLL/SRL/SRA as a log2(WIDTH)-stage barrel shifter; all other logic SHALL reside in alu.
REQ-025 A single shared WIDTH+1-bit adder SHALL serve ADD, SUB, SLT and SLTU.

Verification
REQ-026 A=10, B=20, op 0000 -> ALUResult=30, Zero=0; after next edge FlagsQ=0000.
REQ-027 A=100, B=40, op 0001 -> 60; A=5, B=5, op 0001 -> 0, Zero=1, and after the edge FlagsQ = Z and C set (0110).
REQ-028 A=F0F0F0F0, B=FFFF0000, op 0100 -> 0F0FF0F0; A=1, B=4, op 0101 -> 16; A=32, B=2, op 0110 -> 8; A=80000000, B=FFFFFFE4, op 0111 -> F8000000 (shift amount 4).
REQ-029 A=7FFFFFFF, B=1, op 0000 -> 80000000 and, after the edge, FlagsQ = N and V set (1001).
REQ-030 A=FFFFFFFF, B=1: op 1000 -> 1; op 1001 -> 0; op 1111 -> 0 with Zero=1.
REQ-031 Assert reset for one edge after a flag-setting op -> FlagsQ=0000 while ALUResult still tracks the inputs.
